sobel_window_ctrl: RTL and testbench
====================================

Name: sobel_window_ctrl

Overview:
- Sequencing controller for the 3x3 pixel-window register bank and line buffers in the Avalon-ST edge-detection datapath.
- Tracks column and row position of an incoming Avalon-ST pixel frame and issues load/clear strobes to the window registers and write strobes/addresses to the line buffers.
- Flags when the window holds a complete interior 3x3 neighbourhood, and detects malformed frames (bad SOP/EOP).

Parameters:
- IMG_WIDTH, 640, pixels per row (>=3)
- IMG_HEIGHT, 480, rows per frame (>=3)
- COL_W, 10, column counter width (2^COL_W >= IMG_WIDTH)
- ROW_W, 9, row counter width (2^ROW_W >= IMG_HEIGHT)

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- snk_valid_i  in  1  Avalon-ST sink valid
- snk_sop_i  in  1  start of packet (first pixel of frame)
- snk_eop_i  in  1  end of packet (last pixel of frame)
- snk_ready_o  out  1  Avalon-ST sink ready
- src_ready_i  in  1  downstream filter ready
- win_ld_o  out  1  load strobe to window registers and line-buffer shift
- win_clear_o  out  1  clear strobe to window registers
- lb_wr_o  out  1  line-buffer write enable
- lb_addr_o  out  COL_W  line-buffer address (current column)
- win_valid_o  out  1  window holds valid neighbourhood (one-cycle pulse)
- col_o  out  COL_W  column of the pixel last accepted
- row_o  out  ROW_W  row of the pixel last accepted
- frame_err_o  out  1  malformed-frame pulse

Behaviour:
- Clock clk_i. Reset rst_i is asynchronous and active-high. All flops reset to 0. State resets to IDLE. snk_ready_o is 0 during reset.
- Accept: a beat is accepted when snk_valid_i & snk_ready_o.
- States:
  - IDLE: snk_ready_o = src_ready_i. An accepted beat with sop goes to ACTIVE as pixel (0,0). An accepted beat without sop is discarded: no strobes, no error.
  - ACTIVE: snk_ready_o = src_ready_i. Each accepted beat advances col. Col wraps at IMG_WIDTH-1 to 0 and increments row.
  - DRAIN: snk_ready_o = 1. Beats are discarded. An accepted beat with eop goes to IDLE.
- Strobes in the accept cycle (combinational, gated by accept, IDLE/ACTIVE only):
  - win_ld_o = 1 and lb_wr_o = 1.
  - lb_addr_o = column of the beat being accepted.
- Registered outputs, updated on the cycle after accept:
  - col_o and row_o take the accepted position.
  - win_valid_o pulses high for one cycle when the accepted position has row>=2 and col>=2.
  - win_clear_o pulses high for one cycle after accepting col=IMG_WIDTH-1. The window registers prioritise clear over load.
- Latency: accept to win_valid_o is 1 cycle. Downstream must take the pulse because src_ready_i was high at accept. Throughput is 1 pixel/cycle.
- Frame end: accepting (IMG_WIDTH-1, IMG_HEIGHT-1) with eop goes to IDLE and zeroes the counters.
- Errors (frame_err_o pulses for one cycle after the offending accept):
  - sop in ACTIVE: counters restart; the beat becomes pixel (0,0); stay in ACTIVE.
  - eop before the last pixel: beat is processed normally, then go to IDLE.
  - last pixel without eop: beat is processed normally, then go to DRAIN.
  - sop and eop on the same beat: treated as sop with early eop. Pulse error, go to IDLE.
- Backpressure: with src_ready_i=0 nothing is accepted, counters hold, and all strobes are 0.
- Reset mid-frame: return to IDLE immediately. The next frame must begin with sop.

Optional Feature:
- Macro SOBEL_CTRL_BORDER_EN.
- Defined: win_valid_o pulses for every accepted pixel in IDLE/ACTIVE, including borders. Adds output port border_o (1 bit, registered, reset 0), high with win_valid_o when row<2 or col<2.
- Undefined: win_valid_o pulses for interior pixels only. border_o does not exist.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3 unless noted):
- Reset mid-frame → all outputs 0 and state IDLE. Next non-sop beat is discarded with no win_ld_o.
- Clean 12-beat frame, src_ready_i=1 → 12 win_ld_o; win_valid_o exactly twice, after (2,2) and (3,2); win_clear_o after beats 4, 8 and 12; no frame_err_o; back in IDLE.
- Same frame with src_ready_i toggling every other cycle → identical strobe sequence, stretched; counters hold while ready=0.
- sop injected at beat 6 → frame_err_o pulse; col_o=0 and row_o=0 after that beat; full frame follows normally.
- eop at beat 5 → frame_err_o pulse and IDLE. No eop at beat 12 → frame_err_o, DRAIN, snk_ready_o=1 until an eop beat, then IDLE.
- With SOBEL_CTRL_BORDER_EN → 12 win_valid_o pulses; border_o=1 on 10, 0 on (2,2) and (3,2).

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: sequences the 3x3 window registers and line buffers
// for an Avalon-ST pixel frame. It tracks the column and row, issues the
// load/clear/write strobes, flags interior windows and malformed frames.
// Optional macro SOBEL_CTRL_BORDER_EN: win_valid_o fires for every pixel
// and the extra border_o output marks border positions.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             snk_valid_i,
    input  logic             snk_sop_i,
    input  logic             snk_eop_i,
    output logic             snk_ready_o,
    input  logic             src_ready_i,
    output logic             win_ld_o,
    output logic             win_clear_o,
    output logic             lb_wr_o,
    output logic [COL_W-1:0] lb_addr_o,
    output logic             win_valid_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             frame_err_o
`ifdef SOBEL_CTRL_BORDER_EN
    ,
    output logic             border_o
`endif
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;        // position of the next expected pixel
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] pcol_q, pcol_d;      // position of the last accepted pixel
    logic [ROW_W-1:0] prow_q, prow_d;
    logic             valid_q, valid_d;
    logic             clear_q, clear_d;
    logic             err_q, err_d;
    logic             border_q, border_d;

    logic             ready;
    logic             accept;
    logic             take;
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;
    logic             last_col;
    logic             last_pix;
    logic             is_border;

    // Handshake and position of the beat currently offered.
    always_comb begin
        ready     = ~rst_i & ((state_q == DRAIN) | src_ready_i);
        accept    = snk_valid_i & ready;
        take      = accept & ((state_q == ACTIVE) | ((state_q == IDLE) & snk_sop_i));
        pix_col   = snk_sop_i ? '0 : col_q;
        pix_row   = snk_sop_i ? '0 : row_q;
        last_col  = (pix_col == LAST_COL);
        last_pix  = last_col & (pix_row == LAST_ROW);
        is_border = (pix_row < ROW_W'(2)) | (pix_col < COL_W'(2));
    end

    // Next-state, counter advance and registered-pulse computation.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        pcol_d   = pcol_q;
        prow_d   = prow_q;
        valid_d  = 1'b0;
        clear_d  = 1'b0;
        err_d    = 1'b0;
        border_d = 1'b0;

        if ((state_q == DRAIN) && accept && snk_eop_i) begin
            state_d = IDLE;
        end

        if (take) begin
            pcol_d  = pix_col;
            prow_d  = pix_row;
            clear_d = last_col;
`ifdef SOBEL_CTRL_BORDER_EN
            valid_d  = 1'b1;
            border_d = is_border;
`else
            valid_d  = ~is_border;
`endif
            // (0,0) is never the last pixel, so sop+eop lands in the early-eop term.
            err_d = (snk_sop_i & (state_q == ACTIVE)) |
                    (snk_eop_i & ~last_pix) |
                    (~snk_eop_i & last_pix);

            if (snk_eop_i) begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
            end else if (last_pix) begin
                state_d = DRAIN;
                col_d   = '0;
                row_d   = '0;
            end else begin
                state_d = ACTIVE;
                if (last_col) begin
                    col_d = '0;
                    row_d = pix_row + ROW_W'(1);
                end else begin
                    col_d = pix_col + COL_W'(1);
                    row_d = pix_row;
                end
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            pcol_q   <= '0;
            prow_q   <= '0;
            valid_q  <= 1'b0;
            clear_q  <= 1'b0;
            err_q    <= 1'b0;
            border_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pcol_q   <= pcol_d;
            prow_q   <= prow_d;
            valid_q  <= valid_d;
            clear_q  <= clear_d;
            err_q    <= err_d;
            border_q <= border_d;
        end
    end

    assign snk_ready_o = ready;
    assign win_ld_o    = take;
    assign lb_wr_o     = take;
    assign lb_addr_o   = pix_col;
    assign win_valid_o = valid_q;
    assign win_clear_o = clear_q;
    assign col_o       = pcol_q;
    assign row_o       = prow_q;
    assign frame_err_o = err_q;
`ifdef SOBEL_CTRL_BORDER_EN
    assign border_o    = border_q;
`else
    logic unused_border;
    assign unused_border = border_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 4x3 image: a driver issues
// directed and random beats and pushes expectations from a linear-index
// frame model; a monitor pops and compares as the DUT presents strobes.
module tb_sobel_window_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 2;
    localparam int RW = 2;
`ifdef SOBEL_CTRL_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0, src_ready = 1'b0;
    logic          snk_ready_o, win_ld_o, win_clear_o, lb_wr_o, win_valid_o, frame_err_o;
    logic [CW-1:0] lb_addr_o, col_o;
    logic [RW-1:0] row_o;
`ifdef SOBEL_CTRL_BORDER_EN
    logic          border_o;
`endif

    always #5 clk = ~clk;

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .snk_valid_i (snk_valid),
        .snk_sop_i   (snk_sop),
        .snk_eop_i   (snk_eop),
        .snk_ready_o (snk_ready_o),
        .src_ready_i (src_ready),
        .win_ld_o    (win_ld_o),
        .win_clear_o (win_clear_o),
        .lb_wr_o     (lb_wr_o),
        .lb_addr_o   (lb_addr_o),
        .win_valid_o (win_valid_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .frame_err_o (frame_err_o)
`ifdef SOBEL_CTRL_BORDER_EN
        ,
        .border_o    (border_o)
`endif
    );

    typedef struct {
        int addr; int col; int row;
        bit valid; bit clear; bit err; bit border;
    } rec_t;
    typedef struct { bit rdy; bit ld; } cyc_t;

    rec_t q_rec[$];
    cyc_t q_cyc[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: mode 0 = waiting for sop, 1 = in frame, 2 = draining.
    int   m_mode = 0;
    int   m_pos  = 0;
    bit   last_acc;
    bit   tgl = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input bit r, input bit v, input bit s, input bit e, input bit src);
        cyc_t c;
        rec_t x;
        int   p;
        @(negedge clk); #1;
        rst = r; snk_valid = v; snk_sop = s; snk_eop = e; src_ready = src;
        c.ld = 1'b0;
        last_acc = 1'b0;
        if (r) begin
            c.rdy = 1'b0; m_mode = 0; m_pos = 0;
        end else begin
            c.rdy = (m_mode == 2) ? 1'b1 : src;
            last_acc = v && c.rdy;
            if (last_acc) begin
                if (m_mode == 2) begin
                    if (e) m_mode = 0;
                end else if (m_mode == 1 || s) begin
                    p = s ? 0 : m_pos;
                    x.col = p % W; x.row = p / W; x.addr = x.col;
                    x.border = (x.row < 2) || (x.col < 2);
                    x.valid  = BORDER ? 1'b1 : !x.border;
                    x.clear  = (x.col == W - 1);
                    x.err    = (s && m_mode == 1) || (e && p != W*H - 1) || (!e && p == W*H - 1);
                    if (e) begin m_mode = 0; m_pos = 0; end
                    else if (p == W*H - 1) begin m_mode = 2; m_pos = 0; end
                    else begin m_mode = 1; m_pos = p + 1; end
                    c.ld = 1'b1;
                    q_rec.push_back(x);
                end
            end
        end
        q_cyc.push_back(c);
    endtask

    // Offer one beat until it is taken; tog alternates src_ready every cycle.
    task automatic send_beat(input bit s, input bit e, input bit tog);
        for (int k = 0; k < 40; k++) begin
            tgl = ~tgl;
            cycle(1'b0, 1'b1, s, e, tog ? tgl : 1'b1);
            if (last_acc) return;
        end
        chk("beat_accept_timeout", 0, 1);
    endtask

    // kind: 0 clean, 1 sop at beat 6 then full frame, 2 eop at beat 5, 3 no eop at beat 12
    task automatic send_frame(input int kind, input bit tog);
        int n;
        bit s, e;
        n = (kind == 1) ? 17 : (kind == 2) ? 5 : 12;
        for (int i = 0; i < n; i++) begin
            s = (i == 0) || (kind == 1 && i == 5);
            e = (i == n - 1) && (kind != 3);
            send_beat(s, e, tog);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_col"}, col_o, 0);
        chk({tag, "_row"}, row_o, 0);
        chk({tag, "_pulses"}, {win_valid_o, win_clear_o, frame_err_o, win_ld_o, lb_wr_o}, 0);
        chk({tag, "_ready"}, snk_ready_o, 0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #3 check_quiet("reset");
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: compare handshake each cycle, pop a record on every load strobe.
    initial begin
        cyc_t c;
        rec_t cur;
        bit   have;
        forever begin
            @(negedge clk); #3;
            have = 1'b0;
            if (q_cyc.size() > 0) begin
                c = q_cyc.pop_front();
                chk("snk_ready", snk_ready_o, c.rdy);
                chk("win_ld", win_ld_o, c.ld);
                chk("lb_wr", lb_wr_o, c.ld);
                if (win_ld_o || c.ld) begin
                    if (q_rec.size() > 0) begin
                        cur = q_rec.pop_front();
                        have = win_ld_o;
                        if (have) chk("lb_addr", lb_addr_o, cur.addr);
                    end else begin
                        chk("unexpected_load", 1, 0);
                    end
                end
            end
            @(posedge clk); #1;
            if (have) begin
                chk("col_o", col_o, cur.col);
                chk("row_o", row_o, cur.row);
                chk("win_valid", win_valid_o, cur.valid);
                chk("win_clear", win_clear_o, cur.clear);
                chk("frame_err", frame_err_o, cur.err);
`ifdef SOBEL_CTRL_BORDER_EN
                chk("border", border_o, cur.border);
`endif
            end else begin
                chk("idle_pulses", {win_valid_o, win_clear_o, frame_err_o}, 0);
            end
        end
    end

    // Driver: directed frames, then constrained-random traffic.
    initial begin
        bit s, e, v, src;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #3 check_quiet("init");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(0, 1'b0);
        send_frame(0, 1'b1);
        send_frame(1, 1'b0);
        send_frame(2, 1'b0);
        send_frame(3, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(0, 1'b0);

        send_beat(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_beat(1'b0, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 400 == 0) do_reset();
            v   = ($urandom % 10) < 7;
            src = ($urandom % 4) != 0;
            s   = (m_mode != 1) ? ($urandom % 3 == 0) : ($urandom % 50 == 0);
            if (m_mode == 1 && m_pos == W*H - 1) e = ($urandom % 6) != 0;
            else e = ($urandom % ((m_mode == 2) ? 4 : 50)) == 0;
            cycle(1'b0, v, s, e, src);
        end

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #5;
        chk("rec_queue_empty", q_rec.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
